// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU types for the common data bus transmit side.
// Tags, broadcast bundle and per-FU queue entry.
package cpu_types;

  typedef enum logic [2:0] {
    INVALID = 3'd0,
    RS_ALU1 = 3'd1,
    RS_ALU2 = 3'd2,
    RS_MUL1 = 3'd3,
    RS_MUL2 = 3'd4,
    RS_LD1  = 3'd5,
    RS_LD2  = 3'd6,
    RS_ST1  = 3'd7
  } RS_tag_type;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_entry_t;

  localparam int CDB_N_FU = 4;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Per-FU result queue: circular buffer with occupancy count.
// Guards push-on-full and pop-on-empty internally.
module cdb_fifo
  import cpu_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_entry,
  input  logic       pop,
  output cdb_entry_t head_entry,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  cdb_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty      = (r_cnt == '0);
  assign full       = (r_cnt == CW'(DEPTH));
  assign w_push     = push & ~full;
  assign w_pop      = pop & ~empty;
  assign head_entry = r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (RST_N && !flush && w_push)
      r_mem[r_wr] <= push_entry;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit arbiter: per-FU queues, round-robin pick,
// one registered tag/data broadcast per cycle.
module cdb_arbiter
  import cpu_types::*;
#(
  parameter int N_FU  = CDB_N_FU,
  parameter int DEPTH = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      flush,
  input  logic [N_FU-1:0]           fu_valid,
  input  RS_tag_type [N_FU-1:0]     fu_tag,
  input  logic [N_FU-1:0][31:0]     fu_data,
  output logic [N_FU-1:0]           fu_ready,
  output cdb_t                      cdb_out,
  output logic                      cdb_valid,
  output logic [$clog2(N_FU)-1:0]   grant_idx
);

  localparam int GW = $clog2(N_FU);

  logic [N_FU-1:0] w_empty;
  logic [N_FU-1:0] w_full;
  logic [N_FU-1:0] w_push;
  logic [N_FU-1:0] w_pop;
  logic [N_FU-1:0] w_rot;
  cdb_entry_t      w_entry [N_FU];
  cdb_entry_t      w_head  [N_FU];
  logic [GW-1:0]   r_rr;
  logic [GW-1:0]   w_off;
  logic [GW-1:0]   w_g;
  logic [GW-1:0]   w_rr_nxt;
  logic            w_win;

  for (genvar i = 0; i < N_FU; i++) begin : g_q
    assign fu_ready[i]  = ~w_full[i];
    assign w_entry[i]   = '{tag: fu_tag[i], data: fu_data[i]};
    // INVALID pushes are handshaked but never stored.
    assign w_push[i]    = fu_valid[i] & fu_ready[i] &
                          (fu_tag[i] != INVALID) & ~flush;
    assign w_pop[i]     = w_win & (w_g == GW'(i)) & ~flush;

    cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .flush      (flush),
      .push       (w_push[i]),
      .push_entry (w_entry[i]),
      .pop        (w_pop[i]),
      .head_entry (w_head[i]),
      .empty      (w_empty[i]),
      .full       (w_full[i])
    );

    always_ff @(posedge CLK) begin
      if (RST_N && !flush && fu_valid[i] && fu_ready[i])
        a_tag: assert (fu_tag[i] != INVALID)
          else $warning("cdb_arbiter: INVALID tag on FU %0d discarded", i);
    end
  end

  // Rotate so rr_ptr sits at bit 0, find lowest set, rotate back.
  always_comb begin
    w_rot = '0;
    w_win = 1'b0;
    w_off = '0;
    for (int j = 0; j < N_FU; j++)
      w_rot[j] = ~w_empty[(j + int'(r_rr)) % N_FU];
    for (int j = N_FU - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_win = 1'b1;
        w_off = GW'(j);
      end
    end
    w_g      = GW'((int'(w_off) + int'(r_rr)) % N_FU);
    w_rr_nxt = GW'((int'(w_g) + 1) % N_FU);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cdb_out   <= '{tag: INVALID, data: '0};
      cdb_valid <= 1'b0;
      grant_idx <= '0;
      r_rr      <= '0;
    end else if (flush || !w_win) begin
      cdb_out   <= '{tag: INVALID, data: '0};
      cdb_valid <= 1'b0;
    end else begin
      cdb_out   <= '{tag: w_head[w_g].tag,
                     data: w_head[w_g].data};
      cdb_valid <= 1'b1;
      grant_idx <= w_g;
      r_rr      <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_cdb_arbiter;
  import cpu_types::*;

  localparam int N = 4;
  localparam int D = 2;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 flush = 1'b0;
  logic [N-1:0]         fu_valid = '0;
  RS_tag_type [N-1:0]   fu_tag;
  logic [N-1:0][31:0]   fu_data = '0;
  logic [N-1:0]         fu_ready;
  cdb_t                 cdb_out;
  logic                 cdb_valid;
  logic [1:0]           grant_idx;

  cdb_arbiter #(.N_FU(N), .DEPTH(D)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .fu_ready  (fu_ready),
    .cdb_out   (cdb_out),
    .cdb_valid (cdb_valid),
    .grant_idx (grant_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [1:0]  g;
    RS_tag_type  tag;
    logic [31:0] data;
  } exp_t;

  cdb_entry_t mq   [N][$];
  cdb_entry_t pend [N][$];
  exp_t       exp_q[$];
  logic [N-1:0] cons = '0;
  logic [N-1:0] mrdy = '1;
  int rr = 0;
  int ghold = 0;
  int checks = 0;
  int failures = 0;

  // Reference model: per-FU queues and a round-robin pointer.
  always @(posedge CLK) begin
    exp_t e;
    logic [N-1:0] rdy;
    cdb_entry_t ent;
    int w;
    e = '{v: 1'b0, g: 2'(ghold), tag: INVALID, data: 32'h0};
    cons = '0;
    if (!RST_N) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
      ghold = 0;
      e.g = 2'd0;
      cons = fu_valid;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      cons = fu_valid;
    end else begin
      for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && mq[(rr + k) % N].size() > 0) w = (rr + k) % N;
      if (w >= 0) begin
        ent = mq[w].pop_front();
        e = '{v: 1'b1, g: 2'(w), tag: ent.tag, data: ent.data};
        rr = (w + 1) % N;
        ghold = w;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && rdy[i]) begin
          cons[i] = 1'b1;
          if (fu_tag[i] != INVALID)
            mq[i].push_back('{tag: fu_tag[i], data: fu_data[i]});
        end
      end
    end
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) mrdy[i] = (mq[i].size() < D);
  end

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({cdb_valid, grant_idx, cdb_out.tag, cdb_out.data} !== e) begin
        failures++;
        $display("FAIL bcast t=%0t got v=%0b g=%0d tag=%0d data=%h need v=%0b g=%0d tag=%0d data=%h",
                 $time, cdb_valid, grant_idx, cdb_out.tag, cdb_out.data,
                 e.v, e.g, e.tag, e.data);
      end
      checks++;
      if (fu_ready !== mrdy) begin
        failures++;
        $display("FAIL ready t=%0t got %b need %b", $time, fu_ready, mrdy);
      end
    end
  end

  function automatic bit busy();
    for (int i = 0; i < N; i++)
      if (pend[i].size() > 0 || mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        fu_valid[i] = 1'b1;
        fu_tag[i]   = pend[i][0].tag;
        fu_data[i]  = pend[i][0].data;
      end else begin
        fu_valid[i] = 1'b0;
        fu_tag[i]   = INVALID;
        fu_data[i]  = 32'h0;
      end
    end
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      if (cons[i] && pend[i].size() > 0) void'(pend[i].pop_front());
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (busy() && c < maxc) begin
      step();
      c++;
    end
    step();
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL drain_timeout got busy after %0d cycles need idle", c);
    end
  endtask

  task automatic put(input int i, input RS_tag_type t, input logic [31:0] d);
    pend[i].push_back('{tag: t, data: d});
  endtask

  initial begin
    for (int i = 0; i < N; i++) fu_tag[i] = INVALID;
    // Reset then idle
    RST_N = 1'b0;
    idle(2);
    RST_N = 1'b1;
    idle(5);
    // Single result latency
    put(2, RS_ALU1, 32'hDEADBEEF);
    drain(10);
    idle(2);
    // Round-robin contention from rr_ptr = 0
    RST_N = 1'b0;
    idle(1);
    RST_N = 1'b1;
    for (int i = 0; i < N; i++) put(i, RS_tag_type'(i + 1), 32'(i + 1));
    step();
    step();
    put(0, RS_MUL2, 32'h55);
    drain(20);
    // Backpressure on FU1 while FU0 floods
    for (int k = 0; k < 8; k++) put(0, RS_LD1, 32'h100 + 32'(k));
    for (int k = 0; k < 3; k++) put(1, RS_LD2, 32'h200 + 32'(k));
    drain(60);
    // Flush with in-flight data
    put(0, RS_ALU1, 32'h10);
    put(0, RS_ALU2, 32'h11);
    put(3, RS_MUL1, 32'h30);
    put(3, RS_MUL2, 32'h31);
    step();
    step();
    put(1, RS_ST1, 32'h21);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(4);
    // INVALID tag drop, then a normal push
    put(0, INVALID, 32'd5);
    step();
    idle(3);
    put(0, RS_ALU2, 32'd7);
    drain(10);
    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (pend[i].size() < 3 && $urandom_range(0, 9) < 4)
          put(i, RS_tag_type'($urandom_range(1, 7)), $urandom);
      flush = ($urandom_range(0, 39) == 0);
      RST_N = ($urandom_range(0, 149) != 0);
      step();
    end
    flush = 1'b0;
    RST_N = 1'b1;
    drain(200);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
